// File: rtl/servo_pwm_decoder_pkg.sv
// Shared timing constants and state types for the servo PWM receive path.
// The transmit side uses the same defaults, so both ends agree on the angle mapping.
package servo_pwm_decoder_pkg;

    localparam int unsigned ANGLE_MAX      = 180;
    localparam int unsigned DEF_FRAME_CLKS = 1000000;
    localparam int unsigned DEF_MIN_HIGH   = 25000;
    localparam int unsigned DEF_MAX_HIGH   = 125000;
    localparam int unsigned DEF_STEP       = (DEF_MAX_HIGH - DEF_MIN_HIGH) / ANGLE_MAX;
    localparam int unsigned DEF_TOL        = 2500;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HIGH,
        ST_CHECK
    } meas_state_t;

    typedef enum logic {
        DV_IDLE,
        DV_RUN
    } div_state_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] lim);
        return (v < lim) ? v + 32'd1 : v;
    endfunction

endpackage

// File: rtl/servo_pwm_decoder_step_div.sv
// Sequential subtract-and-round divider: turns a measured high time into degrees,
// one STEP subtraction per clock, rounding the final remainder to the nearest degree.
module servo_step_div
    import servo_pwm_decoder_pkg::*;
#(
    parameter int unsigned MIN_HIGH = DEF_MIN_HIGH,
    parameter int unsigned STEP     = DEF_STEP
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [31:0] count,
    output logic        busy,
    output logic [7:0]  q,
    output logic        done
);

    localparam logic [31:0] MIN_W  = 32'(MIN_HIGH);
    localparam logic [31:0] STEP_W = 32'(STEP);
    localparam logic [31:0] HALF_W = 32'(STEP / 2);
    localparam logic [7:0]  QMAX   = 8'(ANGLE_MAX);

    div_state_t  r_state;
    div_state_t  w_state_nxt;
    logic [31:0] r_rem;
    logic [31:0] w_rem_nxt;
    logic [7:0]  r_q;
    logic [7:0]  w_q_nxt;
    logic [7:0]  w_q_out;
    logic        w_done;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= DV_IDLE;
            r_rem   <= '0;
            r_q     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_rem   <= w_rem_nxt;
            r_q     <= w_q_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_rem_nxt   = r_rem;
        w_q_nxt     = r_q;
        w_q_out     = r_q;
        w_done      = 1'b0;
        case (r_state)
            DV_RUN: begin
                if (r_rem >= STEP_W && r_q < QMAX) begin
                    w_rem_nxt = r_rem - STEP_W;
                    w_q_nxt   = r_q + 8'd1;
                end else begin
                    w_done      = 1'b1;
                    w_state_nxt = DV_IDLE;
                    if (r_rem >= HALF_W && r_q < QMAX) begin
                        w_q_out = r_q + 8'd1;
                    end
                end
            end
            default: ;
        endcase
        if (start) begin
            w_state_nxt = DV_RUN;
            w_rem_nxt   = (count > MIN_W) ? count - MIN_W : '0;
            w_q_nxt     = '0;
        end
    end

    assign busy = (r_state == DV_RUN);
    assign q    = w_q_out;
    assign done = w_done;

endmodule

// File: rtl/servo_pwm_decoder.sv
// Servo PWM receiver: synchronises pwm_in, measures each high phase, range-checks it
// and hands accepted widths to servo_step_div for conversion back to an angle.
module servo_pwm_decoder
    import servo_pwm_decoder_pkg::*;
#(
    parameter int unsigned FRAME_CLKS = DEF_FRAME_CLKS,
    parameter int unsigned MIN_HIGH   = DEF_MIN_HIGH,
    parameter int unsigned MAX_HIGH   = DEF_MAX_HIGH,
    parameter int unsigned STEP       = DEF_STEP,
    parameter int unsigned TOL        = DEF_TOL
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        pwm_in,
    output logic [7:0]  angle,
    output logic        angle_valid,
    output logic [31:0] high_clks,
    output logic        range_err,
    output logic        signal_lost
);

    localparam logic [31:0] LO_LIM   = 32'(MIN_HIGH - TOL);
    localparam logic [31:0] HI_LIM   = 32'(MAX_HIGH + TOL);
    localparam logic [31:0] CNT_SAT  = HI_LIM + 32'd1;
    localparam logic [31:0] WD_ABORT = 32'(FRAME_CLKS);
    localparam logic [31:0] WD_LOST  = 32'(2 * FRAME_CLKS);

    logic [1:0]  r_sync;
    logic        r_prev;
    logic        w_rise;
    logic        w_fall;
    meas_state_t r_state;
    meas_state_t w_state_nxt;
    logic [31:0] r_count;
    logic [31:0] w_count_nxt;
    logic [31:0] r_wd;
    logic        w_start;
    logic        w_err;
    logic        w_div_busy;
    logic        w_div_done;
    logic [7:0]  w_div_q;

    // Reset to 'high' so a line already high at reset never looks like a rising edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync <= '1;
            r_prev <= 1'b1;
        end else begin
            r_sync <= {r_sync[0], pwm_in};
            r_prev <= r_sync[1];
        end
    end

    assign w_rise = r_sync[1] & ~r_prev;
    assign w_fall = ~r_sync[1] & r_prev;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
        end
    end

    // Conversion runs in the divider, so measurement returns to IDLE straight away and
    // a new high phase can be counted while the previous one is still being converted.
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_start     = 1'b0;
        w_err       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_rise) begin
                    w_state_nxt = ST_HIGH;
                    w_count_nxt = 32'd1;
                end
            end
            ST_HIGH: begin
                if (r_wd >= WD_ABORT) begin
                    w_err       = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (w_fall) begin
                    w_state_nxt = ST_CHECK;
                end else begin
                    w_count_nxt = sat_inc(r_count, CNT_SAT);
                end
            end
            ST_CHECK: begin
                if (r_count < LO_LIM || r_count > HI_LIM) begin
                    w_err       = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (!w_div_busy) begin
                    w_start     = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    servo_step_div #(
        .MIN_HIGH (MIN_HIGH),
        .STEP     (STEP)
    ) u_div (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (w_start),
        .count   (r_count),
        .busy    (w_div_busy),
        .q       (w_div_q),
        .done    (w_div_done)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            angle       <= 8'd90;
            angle_valid <= 1'b0;
            high_clks   <= '0;
            range_err   <= 1'b0;
            signal_lost <= 1'b1;
            r_wd        <= '0;
        end else begin
            angle_valid <= w_div_done;
            range_err   <= w_err;
            if (w_div_done) begin
                angle <= w_div_q;
            end
            if (w_start) begin
                high_clks <= r_count;
            end
            if (w_rise) begin
                r_wd <= '0;
            end else if (r_wd < WD_LOST) begin
                r_wd <= r_wd + 32'd1;
            end
            if (w_div_done) begin
                signal_lost <= 1'b0;
            end else if (r_wd >= WD_LOST) begin
                signal_lost <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_servo_pwm_decoder.sv
// Self-checking bench for servo_pwm_decoder with scaled-down timing parameters.
module tb_servo_pwm_decoder;

    localparam int unsigned FRAME = 3000;
    localparam int unsigned MINH  = 100;
    localparam int unsigned MAXH  = 820;
    localparam int unsigned STEPC = 4;
    localparam int unsigned TOLC  = 20;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        pwm_in;
    logic [7:0]  angle;
    logic        angle_valid;
    logic [31:0] high_clks;
    logic        range_err;
    logic        signal_lost;

    int          n_tests = 0;
    int          n_fail  = 0;
    int unsigned model_angle = 90;

    always #5 clk = ~clk;

    servo_pwm_decoder #(
        .FRAME_CLKS (FRAME),
        .MIN_HIGH   (MINH),
        .MAX_HIGH   (MAXH),
        .STEP       (STEPC),
        .TOL        (TOLC)
    ) u_dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .pwm_in      (pwm_in),
        .angle       (angle),
        .angle_valid (angle_valid),
        .high_clks   (high_clks),
        .range_err   (range_err),
        .signal_lost (signal_lost)
    );

    typedef struct {
        int unsigned high;
        bit          err;
        int unsigned ang;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int unsigned ref_angle(input int unsigned h);
        int unsigned rem;
        int unsigned q;
        rem = (h > MINH) ? h - MINH : 0;
        q   = rem / STEPC;
        if (q >= 180) return 180;
        if (rem - q * STEPC >= STEPC / 2) q++;
        return q;
    endfunction

    function automatic bit ref_reject(input int unsigned h);
        return (h < MINH - TOLC) || (h > MAXH + TOLC);
    endfunction

    task automatic quiet_window(input string nm, input int cycles);
        bit sv, se;
        sv = 0;
        se = 0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            if (angle_valid) sv = 1;
            if (range_err) se = 1;
        end
        chk({nm, " no angle_valid"}, sv, 0);
        chk({nm, " no range_err"}, se, 0);
    endtask

    task automatic pulse(input int unsigned h, input bit exp_err, input int unsigned exp_ang,
                         input string nm, input int unsigned gap);
        bit sv, se;
        int lat;
        @(posedge clk);
        #1 pwm_in = 1'b1;
        repeat (h) @(posedge clk);
        #1 pwm_in = 1'b0;
        sv  = 0;
        se  = 0;
        lat = 0;
        for (int c = 0; c < 200 && !sv && !se; c++) begin
            @(negedge clk);
            lat++;
            if (angle_valid) sv = 1;
            if (range_err) se = 1;
        end
        if (exp_err) begin
            chk({nm, " range_err"}, se, 1);
            chk({nm, " no angle_valid"}, sv, 0);
            chk({nm, " angle held"}, angle, model_angle);
        end else begin
            chk({nm, " angle_valid"}, sv, 1);
            chk({nm, " no range_err"}, se, 0);
            chk({nm, " angle"}, angle, exp_ang);
            chk({nm, " high_clks"}, high_clks, h);
            chk({nm, " latency"}, (lat <= int'(exp_ang) + 6), 1);
            @(negedge clk);
            chk({nm, " single pulse"}, angle_valid, 0);
            chk({nm, " signal_lost clear"}, signal_lost, 0);
            model_angle = exp_ang;
        end
        repeat (gap) @(posedge clk);
    endtask

    task automatic do_reset(input logic level);
        reset_n = 1'b0;
        pwm_in  = level;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        model_angle = 90;
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        int unsigned h;
        int          nv;
        int          ne;
        int unsigned va[2];
        int unsigned vh[2];
        bit          se;
        bit          sv;

        vecs[0]  = '{460, 0, 90};
        vecs[1]  = '{100, 0, 0};
        vecs[2]  = '{820, 0, 180};
        vecs[3]  = '{819, 0, 180};
        vecs[4]  = '{840, 0, 180};
        vecs[5]  = '{841, 1, 0};
        vecs[6]  = '{80, 0, 0};
        vecs[7]  = '{79, 1, 0};
        vecs[8]  = '{141, 0, 10};
        vecs[9]  = '{142, 0, 11};
        vecs[10] = '{90, 0, 0};
        vecs[11] = '{300, 0, 50};

        do_reset(1'b0);
        @(negedge clk);
        chk("reset angle", angle, 90);
        chk("reset high_clks", high_clks, 0);
        chk("reset angle_valid", angle_valid, 0);
        chk("reset range_err", range_err, 0);
        chk("reset signal_lost", signal_lost, 1);
        repeat (5) @(posedge clk);

        foreach (vecs[i]) begin
            pulse(vecs[i].high, vecs[i].err, vecs[i].ang, $sformatf("vec%0d", i), 50);
        end

        for (int i = 0; i < 25; i++) begin
            h = $urandom_range(60, 860);
            pulse(h, ref_reject(h), ref_angle(h), $sformatf("rnd%0d_h%0d", i, h),
                  $urandom_range(20, 200));
        end

        // second rise while the first pulse is still converting
        nv = 0;
        ne = 0;
        for (int c = 0; c < 820 + 10 + 460 + 260; c++) begin
            @(posedge clk);
            #1 pwm_in = (c < 820) || (c >= 830 && c < 1290);
            @(negedge clk);
            if (angle_valid) begin
                if (nv < 2) begin
                    va[nv] = angle;
                    vh[nv] = high_clks;
                end
                nv++;
            end
            if (range_err) ne++;
        end
        chk("overlap valid count", nv, 2);
        chk("overlap range_err count", ne, 0);
        if (nv >= 2) begin
            chk("overlap first angle", va[0], 180);
            chk("overlap first high_clks", vh[0], 820);
            chk("overlap second angle", va[1], 90);
            chk("overlap second high_clks", vh[1], 460);
        end
        model_angle = 90;

        // signal loss and recovery
        repeat (2 * FRAME + 20) @(posedge clk);
        @(negedge clk);
        chk("watchdog signal_lost", signal_lost, 1);
        pulse(460, 0, 90, "recover", 50);

        // stuck high beyond one frame
        pulse(141, 0, 10, "pre_stuck", 20);
        @(posedge clk);
        #1 pwm_in = 1'b1;
        se = 0;
        sv = 0;
        for (int c = 0; c < FRAME + 200 && !se; c++) begin
            @(negedge clk);
            if (range_err) se = 1;
            if (angle_valid) sv = 1;
        end
        chk("stuck range_err", se, 1);
        chk("stuck no angle_valid", sv, 0);
        chk("stuck angle held", angle, model_angle);
        @(posedge clk);
        #1 pwm_in = 1'b0;
        quiet_window("stuck release", 250);
        pulse(300, 0, 50, "post_stuck", 50);

        // line already high at reset: its falling edge must not start a measurement
        do_reset(1'b1);
        repeat (300) @(posedge clk);
        #1 pwm_in = 1'b0;
        quiet_window("high_at_reset", 250);
        pulse(460, 0, 90, "after_high_reset", 50);

        // reset in the middle of a high phase
        pulse(141, 0, 10, "pre_rst_high", 20);
        @(posedge clk);
        #1 pwm_in = 1'b1;
        repeat (200) @(posedge clk);
        #1 reset_n = 1'b0;
        @(negedge clk);
        chk("rst_high angle", angle, 90);
        chk("rst_high high_clks", high_clks, 0);
        chk("rst_high signal_lost", signal_lost, 1);
        pwm_in = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        model_angle = 90;
        quiet_window("rst_high", 250);

        // reset in the middle of a conversion
        pulse(141, 0, 10, "pre_rst_conv", 20);
        @(posedge clk);
        #1 pwm_in = 1'b1;
        repeat (820) @(posedge clk);
        #1 pwm_in = 1'b0;
        repeat (40) @(negedge clk);
        #1 reset_n = 1'b0;
        @(negedge clk);
        chk("rst_conv angle", angle, 90);
        chk("rst_conv signal_lost", signal_lost, 1);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        model_angle = 90;
        quiet_window("rst_conv", 250);
        chk("rst_conv angle after", angle, 90);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
